// File: rtl/timestamp_capture_pkg.sv
// timestamp_capture_pkg
//   Shared types and helpers for the timestamp capture block.
//   - chan_state_e : per-channel hold state (empty / holding / release pending)
//   - sel_width()  : width of the read-channel select bus (never below 1)
package timestamp_capture_pkg;

  typedef enum logic [1:0] {
    CH_EMPTY   = 2'd0,
    CH_FULL    = 2'd1,
    CH_PENDING = 2'd2
  } chan_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timestamp_channel.sv
// timestamp_channel
//   One capture channel: synchroniser, rising-edge detect, hold FSM,
//   capture register and saturating missed-event counter.
//   Ports:
//     clk, rst      clock, async active-high reset
//     latch_async   asynchronous event input (rising edge = capture)
//     release_req   synchronous release request (pulse or level)
//     count         live counter value from the top level
//     rdy           timestamp held
//     cap           captured, latency-compensated timestamp
//     miss          events seen while holding (saturating)
module timestamp_channel
  import timestamp_capture_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int MISS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch_async,
  input  logic                  release_req,
  input  logic [WIDTH-1:0]      count,
  output logic                  rdy,
  output logic [WIDTH-1:0]      cap,
  output logic [MISS_WIDTH-1:0] miss
);

  // The edge is seen SYNC_STAGES-1 cycles after the first stage sampled it;
  // the capture lands one cycle later still, so subtract that distance.
  localparam logic [WIDTH-1:0] COMP = WIDTH'(SYNC_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sync, edge_det;
  chan_state_e            state_q, state_d;
  logic [WIDTH-1:0]       cap_q, cap_d;
  logic [MISS_WIDTH-1:0]  miss_q, miss_d;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign edge_det = sync & ~prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], latch_async};
    prev_d = sync;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CH_EMPTY;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_EMPTY:   if (edge_det) state_d = CH_FULL;
      // A release while the input is still high waits for it to drop, so a
      // long pulse cannot re-trigger a capture straight after release.
      CH_FULL:    if (release_req) state_d = sync ? CH_PENDING : CH_EMPTY;
      CH_PENDING: if (!sync) state_d = CH_EMPTY;
      default:    state_d = CH_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rdy = (state_q != CH_EMPTY);
  end

  // Capture value and miss count
  always_comb begin
    cap_d  = cap_q;
    miss_d = miss_q;
    if (state_q == CH_EMPTY) begin
      if (edge_det) cap_d = count - COMP;
    end else begin
      if (edge_det && (miss_q != {MISS_WIDTH{1'b1}})) miss_d = miss_q + 1'b1;
      if (state_d == CH_EMPTY) miss_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= '0;
      miss_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cap_q  <= cap_d;
      miss_q <= miss_d;
    end
  end

  assign cap  = cap_q;
  assign miss = miss_q;

endmodule

// File: rtl/timestamp_capture.sv
// timestamp_capture
//   Free-running counter with pCHANNELS independent timestamp capture
//   channels and a select-driven read mux for the register bank.
//   Ports:
//     globalClock   sole clock
//     iReset        async active-high reset
//     iLatch        async per-channel event inputs
//     iResetLatch   per-channel release requests
//     iSel          read channel select
//     oCount        live counter
//     oLatch        timestamp of channel iSel
//     oMissed       missed-event count of channel iSel
//     oRdy          per-channel "timestamp held"
//     oWrap         one-cycle pulse while the counter reads 0 after wrapping
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int pCHANNELS    = 4,
  parameter int pWIDTH       = 64,
  parameter int pSYNC_STAGES = 2,
  parameter int pMISS_WIDTH  = 8
) (
  input  logic                                 globalClock,
  input  logic                                 iReset,
  input  logic [pCHANNELS-1:0]                 iLatch,
  input  logic [pCHANNELS-1:0]                 iResetLatch,
  input  logic [sel_width(pCHANNELS)-1:0]      iSel,
  output logic [pWIDTH-1:0]                    oCount,
  output logic [pWIDTH-1:0]                    oLatch,
  output logic [pMISS_WIDTH-1:0]               oMissed,
  output logic [pCHANNELS-1:0]                 oRdy,
  output logic                                 oWrap
);

  localparam int SEL_W = sel_width(pCHANNELS);

  logic [pWIDTH-1:0]                         cnt_q, cnt_d;
  logic                                      wrap_q, wrap_d;
  logic [pCHANNELS-1:0][pWIDTH-1:0]          cap_all;
  logic [pCHANNELS-1:0][pMISS_WIDTH-1:0]     miss_all;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    wrap_d = &cnt_q;   // next value is 0 after all-ones
  end

  always_ff @(posedge globalClock or posedge iReset) begin
    if (iReset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign oCount = cnt_q;
  assign oWrap  = wrap_q;

  for (genvar g = 0; g < pCHANNELS; g++) begin : g_ch
    timestamp_channel #(
      .WIDTH      (pWIDTH),
      .SYNC_STAGES(pSYNC_STAGES),
      .MISS_WIDTH (pMISS_WIDTH)
    ) u_ch (
      .clk        (globalClock),
      .rst        (iReset),
      .latch_async(iLatch[g]),
      .release_req(iResetLatch[g]),
      .count      (cnt_q),
      .rdy        (oRdy[g]),
      .cap        (cap_all[g]),
      .miss       (miss_all[g])
    );
  end

  // Out-of-range selects read as zero.
  always_comb begin
    oLatch  = '0;
    oMissed = '0;
    for (int i = 0; i < pCHANNELS; i++) begin
      if (iSel == SEL_W'(i)) begin
        oLatch  = cap_all[i];
        oMissed = miss_all[i];
      end
    end
  end

endmodule

// File: tb/tb_timestamp_capture.sv
module tb_timestamp_capture;

  logic       globalClock = 1'b0;
  logic       iReset;
  logic [3:0] iLatch, iResetLatch;
  logic [1:0] iSel;
  logic [7:0] oCount, oLatch;
  logic [1:0] oMissed;
  logic [3:0] oRdy;
  logic       oWrap;

  timestamp_capture #(
    .pCHANNELS(4), .pWIDTH(8), .pSYNC_STAGES(2), .pMISS_WIDTH(2)
  ) dut (
    .globalClock(globalClock), .iReset(iReset), .iLatch(iLatch),
    .iResetLatch(iResetLatch), .iSel(iSel), .oCount(oCount),
    .oLatch(oLatch), .oMissed(oMissed), .oRdy(oRdy), .oWrap(oWrap)
  );

  always #5 globalClock = ~globalClock;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;   // edges since reset release

  typedef struct {
    logic [3:0] latch;
    logic [3:0] rel;
    logic [3:0] rdy;
    logic [7:0] val;
    logic [1:0] miss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] latch, input logic [3:0] rel,
                     input logic [3:0] rdy, input logic [7:0] val,
                     input logic [1:0] miss);
    vec_t v;
    v.latch = latch; v.rel = rel; v.rdy = rdy; v.val = val; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  // One edge out of reset; checks the counter and wrap pulse against a model.
  task automatic tick();
    @(posedge globalClock);
    #1;
    n++;
    chk("count", 64'(oCount), 64'(n % 256));
    chk("wrap", 64'(oWrap), 64'((n > 0) && (n % 256 == 0)));
  endtask

  task automatic chk_sel(input logic [1:0] sel, input logic [7:0] val,
                         input logic [1:0] miss);
    iSel = sel;
    #1;
    chk($sformatf("latch[%0d]", sel), 64'(oLatch), 64'(val));
    chk($sformatf("missed[%0d]", sel), 64'(oMissed), 64'(miss));
  endtask

  initial begin
    iReset = 1'b1; iLatch = '0; iResetLatch = '0; iSel = '0;
    #1;
    chk("rst_rdy", 64'(oRdy), 64'(0));
    chk("rst_count", 64'(oCount), 64'(0));
    chk("rst_wrap", 64'(oWrap), 64'(0));
    chk("rst_latch", 64'(oLatch), 64'(0));
    repeat (2) @(posedge globalClock);
    #1 iReset = 1'b0;
    n = 0;

    // Channel 0: capture at count 10, four misses (saturating at 3), release.
    add(4'b0001, 4'b0000, 4'b0000, 8'd0,  2'd0); // e10
    add(4'b0001, 4'b0000, 4'b0000, 8'd0,  2'd0); // e11
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd0); // e12 capture
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd0);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd0);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd0);
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd0); // e16
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd0);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd1); // e18
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd1);
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd1); // e20
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd1);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd2); // e22
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd2);
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd2); // e24
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd2);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd3); // e26
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd3);
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd3); // e28
    add(4'b0001, 4'b0000, 4'b0001, 8'd10, 2'd3);
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd3); // e30 saturated
    add(4'b0000, 4'b0000, 4'b0001, 8'd10, 2'd3);
    add(4'b0000, 4'b0001, 4'b0000, 8'd0,  2'd0); // e32 release
    add(4'b0000, 4'b0000, 4'b0000, 8'd0,  2'd0); // e33

    for (int i = 0; i < 9; i++) begin
      tick();
      chk("idle_rdy", 64'(oRdy), 64'(0));
    end
    foreach (vecs[i]) begin
      iLatch = vecs[i].latch; iResetLatch = vecs[i].rel; iSel = 2'd0;
      tick();
      chk($sformatf("vec%0d_rdy", i), 64'(oRdy), 64'(vecs[i].rdy));
      chk($sformatf("vec%0d_missed", i), 64'(oMissed), 64'(vecs[i].miss));
      if (vecs[i].rdy[0]) chk($sformatf("vec%0d_latch", i), 64'(oLatch), 64'(vecs[i].val));
    end
    iResetLatch = '0;

    // Simultaneous edges on all channels (n=33)
    iLatch = 4'hF;
    tick(); tick();
    chk("sim_rdy_early", 64'(oRdy), 64'(0));
    tick();                                       // e36
    chk("sim_rdy", 64'(oRdy), 64'(4'hF));
    for (int s = 0; s < 4; s++) chk_sel(2'(s), 8'd34, 2'd0);
    iLatch = '0;
    tick(); tick();                               // e37, e38
    iResetLatch = 4'hF;
    tick();                                       // e39
    iResetLatch = '0;
    chk("sim_release", 64'(oRdy), 64'(0));

    // Pending release on channel 1
    iLatch = 4'b0010; iSel = 2'd1;
    tick(); tick(); tick();                       // e42
    chk("pend_rdy", 64'(oRdy), 64'(4'b0010));
    chk_sel(2'd1, 8'd40, 2'd0);
    iResetLatch = 4'b0010;
    tick();                                       // e43 -> pending
    chk("pend_hold", 64'(oRdy), 64'(4'b0010));
    tick();                                       // e44 second release ignored
    iResetLatch = '0;
    chk("pend_hold2", 64'(oRdy), 64'(4'b0010));
    chk_sel(2'd1, 8'd40, 2'd0);
    iLatch = '0;
    tick(); tick();                               // e46: sync just dropped
    chk("pend_before_drop", 64'(oRdy), 64'(4'b0010));
    tick();                                       // e47
    chk("pend_drop", 64'(oRdy), 64'(0));
    chk_sel(2'd1, 8'd40, 2'd0);
    iLatch = 4'b0011;
    tick(); tick();                               // e49
    iLatch = 4'b0010;
    tick();                                       // e50
    chk("recap_rdy", 64'(oRdy), 64'(4'b0011));
    chk_sel(2'd0, 8'd48, 2'd0);
    chk_sel(2'd1, 8'd48, 2'd0);
    iResetLatch = 4'b0010;
    tick();                                       // e51 ch1 pending, ch0 full
    iResetLatch = '0;
    chk("pre_reset_rdy", 64'(oRdy), 64'(4'b0011));

    // Mid-operation reset with iLatch[1] held high
    iReset = 1'b1;
    #1;
    chk("mrst_rdy", 64'(oRdy), 64'(0));
    chk("mrst_count", 64'(oCount), 64'(0));
    chk("mrst_wrap", 64'(oWrap), 64'(0));
    chk_sel(2'd0, 8'd0, 2'd0);
    chk_sel(2'd1, 8'd0, 2'd0);
    repeat (2) @(posedge globalClock);
    #1 iReset = 1'b0;
    n = 0;
    tick(); tick();
    chk("mrst_rdy_e2", 64'(oRdy), 64'(0));
    tick();                                       // e3
    chk("mrst_cap_rdy", 64'(oRdy), 64'(4'b0010));
    chk_sel(2'd1, 8'd1, 2'd0);
    iLatch = '0;
    tick(); tick();                               // e5
    iResetLatch = 4'b0010;
    tick();                                       // e6
    iResetLatch = '0;
    chk("mrst_release", 64'(oRdy), 64'(0));

    // Counter wrap and capture across it
    while (n < 254) tick();
    iLatch = 4'b0100;
    tick();                                       // e255
    iLatch = 4'b1100;
    tick();                                       // e256: count 0, wrap
    tick();                                       // e257
    chk("wrap_rdy2", 64'(oRdy), 64'(4'b0100));
    chk_sel(2'd2, 8'd255, 2'd0);
    tick();                                       // e258
    chk("wrap_rdy3", 64'(oRdy), 64'(4'b1100));
    chk_sel(2'd3, 8'd0, 2'd0);
    chk_sel(2'd2, 8'd255, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timestamp_capture.md
# timestamp_capture

Multi-channel, parametrised successor to the two-register counter latch. A free-running pWIDTH-bit counter runs on globalClock. pCHANNELS asynchronous event inputs are synchronised and edge-detected, and each captures a latency-compensated timestamp into its own hold register. A per-channel ready/release handshake and a saturating missed-event count serve the USB register bank, which reads one channel at a time through a select mux.

## Interface
- pCHANNELS, 4, number of capture channels (1..16)
- pWIDTH, 64, counter and timestamp width (≥ 8)
- pSYNC_STAGES, 2, synchroniser depth on each iLatch bit (2..4)
- pMISS_WIDTH, 8, per-channel missed-event counter width
- globalClock  in  1  sole clock; all state on rising edge
- iReset  in  1  asynchronous, active-high reset
- iLatch  in  pCHANNELS  asynchronous event inputs; rising edge = capture request
- iResetLatch  in  pCHANNELS  release request per channel, synchronous to globalClock, one-cycle pulse or level
- iSel  in  $clog2(pCHANNELS) (min 1)  read-channel select
- oCount  out  pWIDTH  live counter value
- oLatch  out  pWIDTH  captured timestamp of channel iSel (combinational mux)
- oMissed  out  pMISS_WIDTH  missed-event count of channel iSel (combinational mux)
- oRdy  out  pCHANNELS  per-channel "timestamp held" flag
- oWrap  out  1  one-cycle pulse when the counter wraps from all-ones to 0

## Operation
- Counter: resets to 0. Increments by 1 every cycle, mod 2^pWIDTH. The value after the n-th edge following reset release is n.
- Per channel: a pSYNC_STAGES flop chain feeds a prev flop. edge = sync & ~prev.
- Channel FSM has three states:
  - EMPTY: oRdy=0. On edge → FULL; store oCount − (pSYNC_STAGES−1), mod 2^pWIDTH.
  - FULL: oRdy=1. Capture register is frozen. Each edge increments miss, saturating at 2^pMISS_WIDTH−1. On iResetLatch: → EMPTY if sync=0; else → PENDING.
  - PENDING: oRdy=1, value still frozen. → EMPTY when sync=0. Further iResetLatch is ignored.
- Miss counter clears to 0 on every transition into EMPTY.
- iResetLatch in EMPTY is ignored and leaves no pending request.
- Simultaneous edge and iResetLatch in FULL: sync=1, so the channel goes to PENDING and the edge is counted as missed.
- Channels are fully independent. Simultaneous edges on several channels capture the same timestamp.
- Capture value wraps modularly. Compensation across a counter wrap yields e.g. 2^pWIDTH−1.
- iLatch held high through reset release is treated as a rising edge: a capture occurs pSYNC_STAGES cycles later.
- Async reset at any time: counter, sync chains, prev, miss and capture registers go to 0; FSMs go to EMPTY. oRdy=0, oLatch=0, oMissed=0, oWrap=0 immediately.

## Timing
- Input set up before edge k (first sync stage samples it):
  - edge detect is true in the cycle after edge k+pSYNC_STAGES−1;
  - oRdy=1 and oLatch valid after edge k+pSYNC_STAGES;
  - stored value equals the counter value after edge k.
- Release latency: iResetLatch high before edge j with sync=0 gives oRdy=0 and oMissed=0 after edge j.
- Re-arm: an edge detected in the same cycle the channel enters EMPTY is not captured. Capture resumes from the next cycle.
- oLatch/oMissed follow iSel combinationally, with no added latency.
- oWrap is high for exactly the cycle in which oCount=0 following all-ones.
- Minimum input pulse width: 1 cycle, high and low, plus metastability margin. Narrower pulses may be lost.

## Structure
- Package timestamp_capture_pkg holds:
  - the channel state enum (EMPTY, FULL, PENDING);
  - the function computing the select width from pCHANNELS.
- Sub-module timestamp_channel contains the synchroniser, edge detect, FSM, capture register and miss counter. It is instantiated pCHANNELS times in a generate loop.
- The top level holds the counter, wrap pulse and read muxes.

## Test plan
- Capture: reset, raise iLatch[0] before edge 10 (pSYNC_STAGES=2) → oRdy[0]=1 after edge 12, oLatch (iSel=0)=10, oMissed=0.
- Misses and release: after capture, pulse iLatch[0] 3 more times → value unchanged, oMissed=3. Pulse iResetLatch[0] with iLatch low → oRdy[0]=0 and oMissed=0 next cycle.
- Pending release: iResetLatch[1] while iLatch[1] held high → oRdy[1] stays 1. It drops the cycle after sync goes low; the next rising edge captures a new value.
- Simultaneous: edges on all 4 channels before the same edge → all oLatch equal. Walking iSel 0..3 shows identical values.
- Wrap: pWIDTH=8, let the counter reach 255 → oWrap pulses with oCount=0. An event sampled at count 255 with compensation stores 255; sampled at 0 stores 0.
- Mid-operation reset: assert iReset with channels FULL and PENDING → all outputs 0 immediately. iLatch high through release → capture after pSYNC_STAGES cycles.
